// File: rtl/gen_arb_rr_grnt.sv
// -----------------------------------------------------------------------------
// gen_arb_rr_grnt -- grant-issuing stage of a round-robin arbiter.
//
// Arbitrates the request bus against the round-robin priority mask returned by
// the mask-update stage. The grant is registered and one-hot. It is held until
// the owner strobes a release, drops its request, or has held the grant for
// MAX_HOLD cycles. Every grant is followed by a one-cycle idle bubble. The
// bubble gives the mask-update stage time to register the grant that just
// ended, so the mask is never stale when the next arbitration happens.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous reset, ACTIVE HIGH (1 = reset)
//   rqsts     in   [WID]    level-sensitive request bus, one bit per requester
//   mask      in   [WID]    priority window from the mask-update stage
//                           (bit=1 means high priority); used only in IDLE
//   rls       in   release strobe from the current owner; ignored in IDLE
//   grnts     out  [WID]    registered one-hot grant bus, zero when idle
//   grnt_vld  out  registered, equals |grnts
//   grnt_idx  out  [IDX_W]  registered binary index of the grant, 0 when idle
//   tmo       out  registered single-cycle pulse on a timeout release
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module gen_arb_rr_grnt #(
  parameter int WID      = 16,
  parameter int MAX_HOLD = 64,
  parameter int IDX_W    = (WID > 1) ? $clog2(WID) : 1,
  parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WID-1:0]   rqsts,
  input  logic [WID-1:0]   mask,
  input  logic             rls,
  output logic [WID-1:0]   grnts,
  output logic             grnt_vld,
  output logic [IDX_W-1:0] grnt_idx,
  output logic             tmo
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // MAX_HOLD == 0 disables the timeout. In that case the counter is pinned at 0.
  localparam bit             TMO_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WID-1:0]   r_grnts;
  logic             r_vld;
  logic [IDX_W-1:0] r_idx;
  logic             r_tmo;
  logic [CNT_W-1:0] r_cnt;

  // Next-state values
  state_t           w_state_nxt;
  logic [WID-1:0]   w_grnts_nxt;
  logic             w_vld_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_tmo_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration: the masked window wins if it holds any request. Otherwise
  // the full request bus is used. In both cases the lowest set bit wins.
  // ---------------------------------------------------------------------------
  logic [WID-1:0]   w_masked;
  logic [WID-1:0]   w_pool;
  logic [WID-1:0]   w_win_oh;
  logic [IDX_W-1:0] w_win_idx;

  assign w_masked = rqsts & mask;
  assign w_pool   = (|w_masked) ? w_masked : rqsts;
  // x & -x isolates the lowest set bit.
  assign w_win_oh = w_pool & (~w_pool + WID'(1));

  // NOTE: every combinational output gets a default before any branch. This
  // keeps the process free of inferred latches.
  always_comb begin
    w_win_idx = '0;
    // Scanning from the top downward leaves the lowest set bit's index.
    for (int i = WID - 1; i >= 0; i--) begin
      if (w_pool[i]) w_win_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Grant-hold conditions
  // ---------------------------------------------------------------------------
  logic w_own_req;
  logic w_release;
  logic w_timeout;

  assign w_own_req = |(rqsts & r_grnts);
  assign w_release = rls | ~w_own_req;
  // A release in the same cycle takes precedence, so no tmo pulse is raised.
  assign w_timeout = TMO_EN && (r_cnt == CNT_LAST) && !w_release;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grnts_nxt = r_grnts;
    w_vld_nxt   = r_vld;
    w_idx_nxt   = r_idx;
    w_tmo_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      ST_IDLE: begin
        // Requests are taken directly in this cycle. They are not latched.
        if (|rqsts) begin
          w_state_nxt = ST_GRANT;
          w_grnts_nxt = w_win_oh;
          w_vld_nxt   = 1'b1;
          w_idx_nxt   = w_win_idx;
          w_cnt_nxt   = '0;
        end
      end

      ST_GRANT: begin
        if (w_release || w_timeout) begin
          // Returning to IDLE forces the one-cycle bubble before the next grant.
          w_state_nxt = ST_IDLE;
          w_grnts_nxt = '0;
          w_vld_nxt   = 1'b0;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = w_timeout;
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. rst_n is active high and synchronous. It overrides an
  // in-flight grant without raising tmo.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments. All
  // registers then sample their pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
      r_grnts <= '0;
      r_vld   <= 1'b0;
      r_idx   <= '0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grnts <= w_grnts_nxt;
      r_vld   <= w_vld_nxt;
      r_idx   <= w_idx_nxt;
      r_tmo   <= w_tmo_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign grnts    = r_grnts;
  assign grnt_vld = r_vld;
  assign grnt_idx = r_idx;
  assign tmo      = r_tmo;

endmodule

// File: tb/tb_gen_arb_rr_grnt.sv
// -----------------------------------------------------------------------------
// tb_gen_arb_rr_grnt -- directed self-checking bench for gen_arb_rr_grnt.
// WID=4 and MAX_HOLD=4. A small behavioural mask-update stage closes the loop:
// after a grant to index k, it clears mask bit k and every bit below it.
// Reset sets the mask to all ones.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_gen_arb_rr_grnt;

  localparam int WID      = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDX_W    = 2;

  logic             clk;
  logic             rst_n;
  logic [WID-1:0]   rqsts;
  logic [WID-1:0]   mask;
  logic             rls;
  logic [WID-1:0]   grnts;
  logic             grnt_vld;
  logic [IDX_W-1:0] grnt_idx;
  logic             tmo;

  int n_checks = 0;
  int n_pass   = 0;

  gen_arb_rr_grnt #(
    .WID      (WID),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rqsts    (rqsts),
    .mask     (mask),
    .rls      (rls),
    .grnts    (grnts),
    .grnt_vld (grnt_vld),
    .grnt_idx (grnt_idx),
    .tmo      (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mask-update stage model. It registers the grant that is visible on the bus.
  logic [WID:0] mask_tmp;
  assign mask_tmp = (5'b00010 << grnt_idx) - 5'd1;
  always_ff @(posedge clk) begin
    if (rst_n)         mask <= '1;
    else if (grnt_vld) mask <= ~mask_tmp[WID-1:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks every output against the hand-computed grant, index and tmo.
  task automatic chk_out(input string tag, input logic [3:0] eg, input int ei, input logic et);
    check({tag, ".grnts"},    32'(grnts),    32'(eg));
    check({tag, ".grnt_vld"}, 32'(grnt_vld), 32'(|eg));
    check({tag, ".grnt_idx"}, 32'(grnt_idx), 32'(ei));
    check({tag, ".tmo"},      32'(tmo),      32'(et));
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b1;
    rqsts = '0;
    rls   = 1'b0;
    tick();
    tick();
    chk_out("reset", 4'b0000, 0, 1'b0);

    // 1: no requests for 5 cycles
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out($sformatf("idle%0d", c), 4'b0000, 0, 1'b0);
    end

    // 2: all request, rls in the 2nd grant cycle -> rotation 0,1,2,3,0
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    rqsts = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("rr%0d.c1", k), 4'b0001 << seq[k], seq[k], 1'b0);
      tick();
      chk_out($sformatf("rr%0d.c2", k), 4'b0001 << seq[k], seq[k], 1'b0);
      rls = 1'b1;
      tick();
      chk_out($sformatf("rr%0d.bub", k), 4'b0000, 0, 1'b0);
      rls = 1'b0;
    end

    // 3: single requester held -> 4 grant cycles, timeout bubble, grant again
    rqsts = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out($sformatf("hold%0d", c), 4'b0100, 2, 1'b0);
    end
    tick();
    chk_out("tmo.bub", 4'b0000, 0, 1'b1);
    tick();
    chk_out("tmo.regrant", 4'b0100, 2, 1'b0);
    rls = 1'b1;
    tick();
    chk_out("tmo.rls", 4'b0000, 0, 1'b0);
    rls = 1'b0;

    // 4: owner drops its request
    rqsts = 4'b0010;
    tick();
    chk_out("drop.grant", 4'b0010, 1, 1'b0);
    rqsts = 4'b1000;
    tick();
    chk_out("drop.bub", 4'b0000, 0, 1'b0);
    tick();
    chk_out("drop.next", 4'b1000, 3, 1'b0);

    // 6: reset mid-grant drops the grant. Next grant is 0001.
    rqsts = 4'b1111;
    rst_n = 1'b1;
    tick();
    chk_out("rst.mid", 4'b0000, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("rst.after", 4'b0001, 0, 1'b0);

    // 5: release coincides with counter==3 -> no tmo
    for (int c = 1; c < 4; c++) begin
      tick();
      chk_out($sformatf("coin.hold%0d", c), 4'b0001, 0, 1'b0);
    end
    rls = 1'b1;
    tick();
    chk_out("coin.rls", 4'b0000, 0, 1'b0);

    // rls in IDLE has no effect; then mask-based priority (mask=1110)
    rqsts = 4'b0000;
    tick();
    chk_out("idle.rls", 4'b0000, 0, 1'b0);
    rls   = 1'b0;
    rqsts = 4'b0010;
    tick();
    chk_out("prio.g1", 4'b0010, 1, 1'b0);
    rls = 1'b1;
    tick();
    chk_out("prio.bub", 4'b0000, 0, 1'b0);
    // Mask is now 1100. Requester 3 outranks requester 0.
    rls   = 1'b0;
    rqsts = 4'b1001;
    tick();
    chk_out("prio.g3", 4'b1000, 3, 1'b0);
    rqsts = 4'b0000;
    tick();
    chk_out("prio.end", 4'b0000, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gen_arb_rr_grnt.md
Name: gen_arb_rr_grnt

Overview:
- Grant-issuing stage of the round-robin arbiter.
- Consumes the request bus and the round-robin priority mask from the mask-update stage, and produces the registered one-hot grant bus that drives that mask stage.
- Holds each grant until the winner releases, drops its request, or exceeds a configurable hold limit.
- Intended pairing: this block feeds the mask-update stage its grant bus and takes that stage's mask back.

Parameters:
- WID, 16, width in bits of the rqsts, mask and grnts buses.
- MAX_HOLD, 64, maximum number of grant-hold cycles before a forced release. 0 disables the timeout.
- IDX_W, $clog2(WID) (minimum 1), width of grnt_idx.
- CNT_W, $clog2(MAX_HOLD+1) (minimum 1), width of the hold counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-high reset. Asserted when 1; sampled on the clk rising edge.
- rqsts  input  WID  request bus, one bit per requester, level-sensitive.
- mask  input  WID  round-robin mask from the mask-update stage. Bit i=1 means requester i is in the high-priority window.
- rls  input  1  release strobe from the current grant owner. Ignored in IDLE.
- grnts  output  WID  registered one-hot grant bus (all-zero when idle). Also drives the mask-update stage.
- grnt_vld  output  1  registered; equals |grnts.
- grnt_idx  output  IDX_W  registered binary index of the granted bit; 0 when grnt_vld=0.
- tmo  output  1  registered single-cycle pulse indicating a forced release by timeout.

Behaviour:
- Reset (rst_n=1 at an edge): state=IDLE, grnts=0, grnt_vld=0, grnt_idx=0, tmo=0, hold counter=0. Reset takes priority over every other event, including mid-grant: the grant is dropped on the next edge with no tmo.
- FSM has two states, IDLE and GRANT.
- IDLE, rqsts==0: stay in IDLE, outputs hold at zero.
- IDLE, rqsts!=0 (arbitration):
  - masked = rqsts & mask.
  - If masked!=0, the winner is the lowest set bit of masked; otherwise the winner is the lowest set bit of rqsts.
  - Next edge: grnts = onehot(winner), grnt_idx = winner, grnt_vld=1, state=GRANT, counter=0.
  - Latency from request to grant is 1 cycle.
- GRANT, hold: while the owner's rqsts bit=1, rls=0 and the timeout is not reached, grnts is held and the counter increments (saturating at MAX_HOLD).
- GRANT, release condition: rls=1, or the owner's rqsts bit=0.
  - Next edge: grnts=0, state=IDLE, counter=0, tmo=0.
- GRANT, timeout condition: MAX_HOLD!=0, counter==MAX_HOLD-1, and no release condition.
  - Next edge: grnts=0, state=IDLE, tmo=1 for exactly one cycle.
- Release and timeout in the same cycle: treated as a normal release, tmo=0.
- Mandatory one-cycle idle bubble (grnts=0) between consecutive grants. This guarantees the mask-update stage has registered the previous grant before the next arbitration, so mask is never stale. Maximum grant rate is one grant per 2 cycles.
- A requester that wins and immediately re-requests is lower priority than any requester above it: the mask has cleared its own bit and every bit below it.
- Any rqsts change in IDLE is taken in the same cycle; there is no request latching.
- Invariants:
  - grnts is always zero or one-hot.
  - grnts[i]=1 only if rqsts[i]=1 in the arbitration cycle.
  - rls while in IDLE has no effect.
- mask is used combinationally only in IDLE; its value in GRANT is don't-care.
- With MAX_HOLD=1, every grant lasts exactly 1 cycle unless released earlier.

Test Plan:
Bench: WID=4, MAX_HOLD=4, connected to the mask-update stage exactly as in the intended pairing.
- Reset, rqsts=4'b0000 for 5 cycles -> grnts=0, grnt_vld=0, grnt_idx=0, tmo=0 throughout.
- Reset, then rqsts=4'b1111 held, rls pulsed in the 2nd cycle of each grant -> grnts sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001, with grnt_idx 0,1,2,3,0.
- rqsts=4'b0100 held, rls=0 -> grnts=0100 for exactly 4 cycles, then 0000 with tmo=1 for one cycle, then 0100 again.
- Owner drops its request: grant 0010 active, then rqsts 0010 to 1000 -> next edge grnts=0000, following edge grnts=1000, tmo=0.
- Release and timeout coincide: rls=1 in the cycle counter==3 -> grnts=0000 next edge with tmo=0.
- Reset mid-grant: grant 1000 active, rst_n=1 for one cycle with rqsts=1111 -> grnts=0; after reset deasserts, the next grant is 0001 (mask cleared by reset).
